// File: rtl/mem_access_unit.sv
// Word-to-byte memory access unit: splits each 16-bit request from the control unit
// into two byte accesses (low byte first) on a byte-wide memory port.
module mem_access_unit #(
  parameter int unsigned ADDR_WIDTH   = 14,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata
);

  localparam int unsigned AW    = ADDR_WIDTH;
  localparam int unsigned CNT_W = 2;
  // Highest legal word address: its high byte must still be inside the array.
  localparam logic [15:0] MAX_ADDR = 16'((32'd1 << AW) - 32'd2);
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_LO,
    WAIT_LO,
    ISSUE_HI,
    WAIT_HI,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic             write_q, write_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       lo_q, lo_d;

  logic             req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic [15:0]      resp_rdata_q, resp_rdata_d;
  logic             resp_err_q, resp_err_d;
  logic [15:0]      mem_addr_q, mem_addr_d;
  logic [7:0]       mem_wdata_q, mem_wdata_d;
  logic             mem_we_q, mem_we_d;

  logic [15:0]      addr_hi;

  assign addr_hi = 16'(AW'(addr_q + AW'(1)));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      lo_q         <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      lo_q         <= lo_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
    end
  end

  // Memory-port outputs are registered, so they are computed for the state being entered.
  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    lo_d         = lo_q;
    resp_rdata_d = resp_rdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr[AW-1:0];
          wdata_d = req_wdata;
          if (req_addr > MAX_ADDR) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d      = 1'b0;
            state_d    = ISSUE_LO;
            mem_addr_d = 16'(req_addr[AW-1:0]);
            mem_we_d   = req_write;
            if (req_write) begin
              mem_wdata_d = req_wdata[7:0];
            end
          end
        end
      end
      ISSUE_LO: begin
        if (write_q) begin
          state_d     = ISSUE_HI;
          mem_addr_d  = addr_hi;
          mem_wdata_d = wdata_q[15:8];
          mem_we_d    = 1'b1;
        end else begin
          state_d = WAIT_LO;
          cnt_d   = LAT_INIT;
        end
      end
      WAIT_LO: begin
        if (cnt_q == '0) begin
          lo_d       = mem_rdata;
          state_d    = ISSUE_HI;
          mem_addr_d = addr_hi;
        end else begin
          cnt_d = CNT_W'(cnt_q - CNT_W'(1));
        end
      end
      ISSUE_HI: begin
        if (write_q) begin
          state_d = DONE;
        end else begin
          state_d = WAIT_HI;
          cnt_d   = LAT_INIT;
        end
      end
      WAIT_HI: begin
        if (cnt_q == '0) begin
          resp_rdata_d = {mem_rdata, lo_q};
          state_d      = DONE;
        end else begin
          cnt_d = CNT_W'(cnt_q - CNT_W'(1));
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == DONE);
    resp_err_d   = (state_d == DONE) && err_d;
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a latency-1 instance and a latency-3 instance,
// each backed by its own byte-memory model.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Latency-1 instance signals
  logic        req_valid, req_write, req_ready;
  logic [15:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [15:0] resp_rdata, mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_we;

  // Latency-3 instance signals
  logic        req_valid3, req_write3, req_ready3;
  logic [15:0] req_addr3, req_wdata3;
  logic        resp_valid3, resp_err3;
  logic [15:0] resp_rdata3, mem_addr3;
  logic [7:0]  mem_wdata3, mem_rdata3;
  logic        mem_we3;

  mem_access_unit #(.ADDR_WIDTH(14), .READ_LATENCY(1)) dut (
    .clock(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  mem_access_unit #(.ADDR_WIDTH(14), .READ_LATENCY(3)) dut3 (
    .clock(clk), .reset(reset),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_write(req_write3),
    .req_addr(req_addr3), .req_wdata(req_wdata3),
    .resp_valid(resp_valid3), .resp_rdata(resp_rdata3), .resp_err(resp_err3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_we(mem_we3), .mem_rdata(mem_rdata3)
  );

  // Byte memories with a registered read pipeline of the instance's latency
  logic [7:0] mem1 [0:16383];
  logic [7:0] mem3 [0:16383];
  logic [7:0] pipe1;
  logic [7:0] pipe3 [0:2];

  always @(posedge clk) begin
    if (mem_we) mem1[mem_addr[13:0]] <= mem_wdata;
    pipe1 <= mem1[mem_addr[13:0]];
    if (mem_we3) mem3[mem_addr3[13:0]] <= mem_wdata3;
    pipe3[0] <= mem3[mem_addr3[13:0]];
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign mem_rdata  = pipe1;
  assign mem_rdata3 = pipe3[2];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Per-cycle trace of the memory port during the last run_req
  logic [15:0] tr_addr [0:15];
  logic [7:0]  tr_wd   [0:15];
  logic        tr_we   [0:15];

  task automatic run_req(input string name, input logic wr, input logic [15:0] a,
                         input logic [15:0] wd, input int exp_lat, input logic exp_err,
                         input logic [15:0] exp_rd);
    int cyc;
    int we_cnt;
    bit seen;
    @(negedge clk);
    check({name, "/ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
    @(negedge clk);
    // Scramble the request fields while busy; they must be ignored.
    req_valid = 1'b0; req_write = ~wr; req_addr = 16'h2AAA; req_wdata = 16'h5A5A;
    cyc = 1; we_cnt = 0; seen = 1'b0;
    while (!seen && cyc < 40) begin
      if (cyc < 16) begin
        tr_addr[cyc] = mem_addr; tr_wd[cyc] = mem_wdata; tr_we[cyc] = mem_we;
      end
      if (mem_we) we_cnt++;
      if (resp_valid) begin
        seen = 1'b1;
        check({name, "/ready_with_valid"}, 32'(req_ready), 32'd0);
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    check({name, "/latency"}, 32'(cyc), 32'(exp_lat));
    check({name, "/err"}, 32'(resp_err), 32'(exp_err));
    check({name, "/rdata"}, 32'(resp_rdata), 32'(exp_rd));
    check({name, "/we_count"}, 32'(we_cnt), (wr && !exp_err) ? 32'd2 : 32'd0);
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          lat;
    logic        err;
    logic [15:0] rdata;
  } vec_t;

  vec_t vecs [0:8];

  initial begin
    int vr;
    for (int i = 0; i < 16384; i++) begin
      mem1[i] = 8'h00;
      mem3[i] = 8'h00;
    end
    mem3[16'h0100] = 8'hFE;
    mem3[16'h0101] = 8'hCA;

    vecs[0] = '{1'b1, 16'h0010, 16'hBEEF, 3, 1'b0, 16'h0000};
    vecs[1] = '{1'b0, 16'h0010, 16'h0000, 5, 1'b0, 16'hBEEF};
    vecs[2] = '{1'b1, 16'h3FFE, 16'h1234, 3, 1'b0, 16'hBEEF};
    vecs[3] = '{1'b0, 16'h3FFE, 16'h0000, 5, 1'b0, 16'h1234};
    vecs[4] = '{1'b0, 16'h3FFF, 16'h0000, 1, 1'b1, 16'h1234};
    vecs[5] = '{1'b1, 16'h4000, 16'h5555, 1, 1'b1, 16'h1234};
    vecs[6] = '{1'b0, 16'hFFFF, 16'h0000, 1, 1'b1, 16'h1234};
    vecs[7] = '{1'b1, 16'h0000, 16'hA5C3, 3, 1'b0, 16'h1234};
    vecs[8] = '{1'b0, 16'h0000, 16'h0000, 5, 1'b0, 16'hA5C3};

    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_valid3 = 1'b0; req_write3 = 1'b0; req_addr3 = '0; req_wdata3 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset/req_ready", 32'(req_ready), 32'd1);
    check("reset/resp_valid", 32'(resp_valid), 32'd0);
    check("reset/resp_rdata", 32'(resp_rdata), 32'd0);
    check("reset/resp_err", 32'(resp_err), 32'd0);
    check("reset/mem_addr", 32'(mem_addr), 32'd0);
    check("reset/mem_wdata", 32'(mem_wdata), 32'd0);
    check("reset/mem_we", 32'(mem_we), 32'd0);

    for (int i = 0; i < 9; i++) begin
      run_req($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
              vecs[i].lat, vecs[i].err, vecs[i].rdata);
      if (i == 0) begin
        check("wr/c1_we", 32'(tr_we[1]), 32'd1);
        check("wr/c1_addr", 32'(tr_addr[1]), 32'h0010);
        check("wr/c1_data", 32'(tr_wd[1]), 32'hEF);
        check("wr/c2_we", 32'(tr_we[2]), 32'd1);
        check("wr/c2_addr", 32'(tr_addr[2]), 32'h0011);
        check("wr/c2_data", 32'(tr_wd[2]), 32'hBE);
      end
    end
    check("mem/3ffe", 32'(mem1[16'h3FFE]), 32'h34);
    check("mem/3fff", 32'(mem1[16'h3FFF]), 32'h12);
    check("mem/0000", 32'(mem1[16'h0000]), 32'hC3);

    // Back-to-back: write held, then read accepted the cycle after DONE
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0020; req_wdata = 16'h00AA;
    @(negedge clk);
    check("b2b/c1_addr", 32'(mem_addr), 32'h0020);
    check("b2b/c1_data", 32'(mem_wdata), 32'hAA);
    req_addr = 16'h0777; req_wdata = 16'h1111;
    @(negedge clk);
    check("b2b/c2_addr", 32'(mem_addr), 32'h0021);
    check("b2b/c2_data", 32'(mem_wdata), 32'h00);
    @(negedge clk);
    check("b2b/c3_valid", 32'(resp_valid), 32'd1);
    check("b2b/c3_ready", 32'(req_ready), 32'd0);
    req_write = 1'b0; req_addr = 16'h0020;
    @(negedge clk);
    check("b2b/c4_ready", 32'(req_ready), 32'd1);
    check("b2b/c4_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    check("b2b/c5_ready", 32'(req_ready), 32'd0);
    check("b2b/c5_addr", 32'(mem_addr), 32'h0020);
    req_valid = 1'b0; req_addr = 16'h3333;
    vr = 0;
    for (int k = 5; k < 9; k++) begin
      if (resp_valid) vr++;
      @(negedge clk);
    end
    check("b2b/early_valid", 32'(vr), 32'd0);
    check("b2b/c9_valid", 32'(resp_valid), 32'd1);
    check("b2b/c9_rdata", 32'(resp_rdata), 32'h00AA);
    check("b2b/ignored_addr", 32'(mem1[16'h0777]), 32'h00);

    // Reset in cycle 2 of a read
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0010;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst/req_ready", 32'(req_ready), 32'd1);
    check("rst/mem_we", 32'(mem_we), 32'd0);
    check("rst/resp_rdata", 32'(resp_rdata), 32'd0);
    vr = 0;
    for (int k = 0; k < 8; k++) begin
      if (resp_valid) vr++;
      @(negedge clk);
    end
    check("rst/no_resp_valid", 32'(vr), 32'd0);

    // READ_LATENCY=3 instance: read 0x0100 holding 0xCAFE
    @(negedge clk);
    req_valid3 = 1'b1; req_write3 = 1'b0; req_addr3 = 16'h0100;
    @(negedge clk);
    req_valid3 = 1'b0; req_addr3 = 16'h0FFF;
    begin
      int bad_lo, bad_hi, we3, vld3;
      bad_lo = 0; bad_hi = 0; we3 = 0; vld3 = 0;
      for (int k = 1; k <= 8; k++) begin
        if (k <= 4 && mem_addr3 != 16'h0100) bad_lo++;
        if (k >= 5 && mem_addr3 != 16'h0101) bad_hi++;
        if (mem_we3) we3++;
        if (resp_valid3) vld3++;
        @(negedge clk);
      end
      check("l3/addr_lo_held", 32'(bad_lo), 32'd0);
      check("l3/addr_hi_held", 32'(bad_hi), 32'd0);
      check("l3/no_we", 32'(we3), 32'd0);
      check("l3/early_valid", 32'(vld3), 32'd0);
    end
    check("l3/c9_valid", 32'(resp_valid3), 32'd1);
    check("l3/c9_rdata", 32'(resp_rdata3), 32'hCAFE);
    check("l3/c9_err", 32'(resp_err3), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
